// File: rtl/dmem_responder.sv
// Word-organised data-memory responder: captures a mem-stage load/store, waits WAIT_CYCLES, then acks once.
// Latency: ack in the cycle after capture edge + WAIT_CYCLES; stallreq holds the pipeline until the ack cycle.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_ce_i,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [3:0]  req_sel_i,
  input  logic [31:0] req_data_i,
  output logic [31:0] resp_data_o,
  output logic        resp_ack_o,
  output logic        resp_err_o,
  output logic        stallreq_o,
  output logic        busy_o
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [3:0]  cap_sel;
  logic [31:0] cap_data;

  logic [31:0] mem [DEPTH];

  logic                  acc_now;
  logic                  use_in;
  logic                  acc_we;
  logic [31:0]           acc_addr;
  logic [3:0]            acc_sel;
  logic [31:0]           acc_data;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic                  in_range;
  logic                  wr_en;
  logic [31:0]           rd_word;
  logic [31:0]           load_word;

  // With zero wait states the access happens on the capture edge, so the live inputs feed it.
  always_comb begin
    acc_now = 1'b0;
    use_in  = 1'b0;
    if (!rst && req_ce_i) begin
      if (state == ST_IDLE && WAIT_CYCLES == 0) begin
        acc_now = 1'b1;
        use_in  = 1'b1;
      end else if (state == ST_WAIT && cnt == 4'd1) begin
        acc_now = 1'b1;
      end
    end
    acc_we    = use_in ? req_we_i   : cap_we;
    acc_addr  = use_in ? req_addr_i : cap_addr;
    acc_sel   = use_in ? req_sel_i  : cap_sel;
    acc_data  = use_in ? req_data_i : cap_data;
    acc_idx   = acc_addr[ADDR_WIDTH+1:2];
    in_range  = (acc_addr >> (ADDR_WIDTH + 2)) == 32'd0;
    wr_en     = acc_now & acc_we & in_range;
    rd_word   = mem[acc_idx];
    load_word = (!acc_we && in_range) ? rd_word : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_sel[i]) mem[acc_idx][8*i +: 8] <= acc_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      cap_we      <= 1'b0;
      cap_addr    <= 32'd0;
      cap_sel     <= 4'd0;
      cap_data    <= 32'd0;
      resp_data_o <= 32'd0;
      resp_ack_o  <= 1'b0;
      resp_err_o  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          resp_data_o <= 32'd0;
          resp_ack_o  <= 1'b0;
          resp_err_o  <= 1'b0;
          if (req_ce_i) begin
            cap_we   <= req_we_i;
            cap_addr <= req_addr_i;
            cap_sel  <= req_sel_i;
            cap_data <= req_data_i;
            cnt      <= WAIT_INIT;
            if (WAIT_CYCLES == 0) begin
              state       <= ST_ACK;
              resp_ack_o  <= 1'b1;
              resp_err_o  <= ~in_range;
              resp_data_o <= load_word;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // A dropped request means the pipeline flushed this access: abandon it silently.
          if (!req_ce_i) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              state       <= ST_ACK;
              resp_ack_o  <= 1'b1;
              resp_err_o  <= ~in_range;
              resp_data_o <= load_word;
            end
          end
        end
        ST_ACK: begin
          state       <= ST_IDLE;
          resp_data_o <= 32'd0;
          resp_ack_o  <= 1'b0;
          resp_err_o  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign stallreq_o = req_ce_i & (state != ST_ACK);
  assign busy_o     = (state != ST_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: dut0 has zero wait states, dut1 has two; a timeline model predicts every cycle.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst;
  logic [1:0]       ce, we;
  logic [1:0][31:0] addr, wdat;
  logic [1:0][3:0]  sel;
  logic [1:0][31:0] rdat;
  logic [1:0]       ack, err, stall, busy;

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst[0]), .req_ce_i(ce[0]), .req_we_i(we[0]), .req_addr_i(addr[0]),
    .req_sel_i(sel[0]), .req_data_i(wdat[0]), .resp_data_o(rdat[0]), .resp_ack_o(ack[0]),
    .resp_err_o(err[0]), .stallreq_o(stall[0]), .busy_o(busy[0]));

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst[1]), .req_ce_i(ce[1]), .req_we_i(we[1]), .req_addr_i(addr[1]),
    .req_sel_i(sel[1]), .req_data_i(wdat[1]), .resp_data_o(rdat[1]), .resp_ack_o(ack[1]),
    .resp_err_o(err[1]), .stallreq_o(stall[1]), .busy_o(busy[1]));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  // Model: the cycle of the expected ack, the busy window, the response, and a reference memory.
  int          ack_at [2];
  int          bf [2];
  int          bt [2];
  logic [31:0] exp_data [2];
  logic        exp_err [2];
  logic [31:0] ref_mem [2][1024];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wc(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d got %h exp %h", name, d, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    bit ea;
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        ea = (cyc == ack_at[d]);
        chk("ack", d, 32'(ack[d]), 32'(ea));
        chk("err", d, 32'(err[d]), ea ? 32'(exp_err[d]) : 32'd0);
        chk("data", d, rdat[d], ea ? exp_data[d] : 32'd0);
        chk("busy", d, 32'(busy[d]), 32'(cyc >= bf[d] && cyc <= bt[d]));
        chk("stall", d, 32'(stall[d]), 32'(ce[d] && !ea));
      end
    end
  end

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one request and wait for its ack; lat is ack cycle minus capture edge, nst counts stall cycles.
  task automatic req(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er,
                     output int lat, output int nst);
    int n;
    int idx;
    bit in_ack;
    logic ee;
    logic [31:0] ed;
    in_ack = (cyc == ack_at[d]);
    n = in_ack ? cyc + 2 : cyc + 1;
    ce[d] = 1'b1; we[d] = w; addr[d] = a; sel[d] = s; wdat[d] = wd;
    idx = int'(a[11:2]);
    ee = (a[31:12] != 20'd0);
    ed = (!w && !ee) ? ref_mem[d][idx] : 32'd0;
    if (in_ack) begin
      @(negedge clk);
      #1;
    end
    ack_at[d] = n + wc(d); bf[d] = n; bt[d] = n + wc(d);
    exp_data[d] = ed; exp_err[d] = ee;
    if (w && !ee)
      for (int i = 0; i < 4; i++)
        if (s[i]) ref_mem[d][idx][8*i +: 8] = wd[8*i +: 8];
    if (in_ack) begin
      @(posedge clk);
      #1;
    end else begin
      #1;
    end
    nst = 0;
    lat = -1;
    for (int t = 0; t < 40; t++) begin
      if (ack[d]) begin
        lat = cyc - n;
        break;
      end
      if (stall[d]) nst++;
      @(posedge clk);
      #1;
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout dut%0d cyc %0d got no ack exp ack", d, cyc);
    end
    rd = rdat[d];
    er = err[d];
    ce[d] = 1'b0;
  endtask

  // Start a store and abandon it in its first wait cycle, either by a flush or by a reset pulse.
  task automatic abort_store(input int d, input logic [31:0] a, input logic [31:0] wd, input bit use_rst);
    int n;
    n = cyc + 1;
    ce[d] = 1'b1; we[d] = 1'b1; addr[d] = a; sel[d] = 4'hF; wdat[d] = wd;
    ack_at[d] = n + wc(d); bf[d] = n; bt[d] = n + wc(d);
    @(posedge clk);
    #1;
    ce[d] = 1'b0;
    if (use_rst) rst[d] = 1'b1;
    ack_at[d] = -1;
    bt[d] = n;
    @(posedge clk);
    #1;
    rst[d] = 1'b0;
    chk("abort_busy", d, 32'(busy[d]), 32'd0);
    chk("abort_ack", d, 32'(ack[d]), 32'd0);
    chk("abort_err", d, 32'(err[d]), 32'd0);
    chk("abort_data", d, rdat[d], 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc %0d got no finish exp finish", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic er;
    int lat, nst, c0, c1;
    rst = 2'b11; ce = '0; we = '0; addr = '0; sel = '0; wdat = '0;
    for (int d = 0; d < 2; d++) begin
      ack_at[d] = -1; bf[d] = -1; bt[d] = -2; exp_data[d] = '0; exp_err[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 2'b00;
    chk_on = 1'b1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ack", d, 32'(ack[d]), 32'd0);
      chk("rst_err", d, 32'(err[d]), 32'd0);
      chk("rst_data", d, rdat[d], 32'd0);
      chk("rst_busy", d, 32'(busy[d]), 32'd0);
      chk("rst_stall", d, 32'(stall[d]), 32'd0);
    end

    req(1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, er, lat, nst);
    chk("st_lat", 1, 32'(lat), 32'd2);
    chk("st_nstall", 1, 32'(nst), 32'd3);
    chk("st_rdata", 1, rd, 32'd0);
    req(1, 1'b0, 32'h10, 4'h1, 32'h0, rd, er, lat, nst);
    chk("ld_word", 1, rd, 32'hDEADBEEF);
    req(1, 1'b1, 32'h10, 4'b0010, 32'h0000_5500, rd, er, lat, nst);
    req(1, 1'b0, 32'h10, 4'hF, 32'h0, rd, er, lat, nst);
    chk("ld_partial", 1, rd, 32'hDEAD55EF);
    req(1, 1'b1, 32'h10, 4'b0000, 32'hFFFF_FFFF, rd, er, lat, nst);
    chk("sel0_lat", 1, 32'(lat), 32'd2);
    req(1, 1'b0, 32'h10, 4'hF, 32'h0, rd, er, lat, nst);
    chk("ld_sel0", 1, rd, 32'hDEAD55EF);

    req(1, 1'b1, 32'h0, 4'hF, 32'hA5A5A5A5, rd, er, lat, nst);
    req(1, 1'b0, 32'h0001_0000, 4'hF, 32'h0, rd, er, lat, nst);
    chk("oor_ld_err", 1, 32'(er), 32'd1);
    chk("oor_ld_data", 1, rd, 32'd0);
    req(1, 1'b1, 32'h0001_0000, 4'hF, 32'hFFFF_FFFF, rd, er, lat, nst);
    chk("oor_st_err", 1, 32'(er), 32'd1);
    req(1, 1'b0, 32'h0, 4'hF, 32'h0, rd, er, lat, nst);
    chk("oor_word0", 1, rd, 32'hA5A5A5A5);
    chk("oor_word0_err", 1, 32'(er), 32'd0);

    req(1, 1'b1, 32'h20, 4'hF, 32'hCAFEF00D, rd, er, lat, nst);
    idle(1);
    abort_store(1, 32'h20, 32'h0BADBEEF, 1'b0);
    req(1, 1'b0, 32'h20, 4'hF, 32'h0, rd, er, lat, nst);
    chk("flush_word", 1, rd, 32'hCAFEF00D);

    req(1, 1'b1, 32'h30, 4'hF, 32'h87654321, rd, er, lat, nst);
    idle(1);
    abort_store(1, 32'h30, 32'h12345678, 1'b1);
    req(1, 1'b0, 32'h30, 4'hF, 32'h0, rd, er, lat, nst);
    chk("rst_word", 1, rd, 32'h87654321);
    chk("rst_after_lat", 1, 32'(lat), 32'd2);

    // Zero-wait-state unit: request held high across acks.
    req(0, 1'b1, 32'h0, 4'hF, 32'h11111111, rd, er, lat, nst);
    chk("w0_lat", 0, 32'(lat), 32'd0);
    chk("w0_nstall", 0, 32'(nst), 32'd1);
    req(0, 1'b1, 32'h4, 4'hF, 32'h22222222, rd, er, lat, nst);
    req(0, 1'b1, 32'h8, 4'hF, 32'h33333333, rd, er, lat, nst);
    req(0, 1'b0, 32'h0, 4'hF, 32'h0, rd, er, lat, nst);
    c0 = cyc;
    chk("b2b_ld0", 0, rd, 32'h11111111);
    req(0, 1'b0, 32'h4, 4'hF, 32'h0, rd, er, lat, nst);
    c1 = cyc;
    chk("b2b_ld1", 0, rd, 32'h22222222);
    chk("b2b_period1", 0, 32'(c1 - c0), 32'd2);
    req(0, 1'b0, 32'h8, 4'hF, 32'h0, rd, er, lat, nst);
    chk("b2b_ld2", 0, rd, 32'h33333333);
    chk("b2b_period2", 0, 32'(cyc - c1), 32'd2);

    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
